// File: rtl/ahb_master_if.sv
// Command/response and AHB-Lite bus bundle for ahb_master.
// The master modport is the bus master's view; slave is the command source and AHB slave side.
interface ahb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        hsel;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output hsel, haddr, htrans, hsize, hwrite, hburst, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  hsel, haddr, htrans, hsize, hwrite, hburst, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: one command in, one NONSEQ transfer out, one response pulse back.
// Illegal size/alignment combinations are answered with an error and never reach the bus.
module ahb_master (
    input  logic          clk,
    input  logic          n_rst,
    ahb_master_if.master  bus
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, RESP} state_t;

    state_t      state, state_nxt;
    logic        wr_q;
    logic [7:0]  addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        cmd_illegal;
    logic        load_cmd;
    logic        rsp_load;
    logic        rsp_err_nxt;
    logic [31:0] rsp_data_nxt;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic [31:0] rdata_shift;

    always_comb begin
        cmd_illegal = (bus.cmd_size == 2'b11)
                   || (bus.cmd_size == 2'b01 && bus.cmd_addr[0])
                   || (bus.cmd_size == 2'b10 && bus.cmd_addr[1:0] != 2'b00);
    end

    // Lane placement and extraction both key off the registered address and size.
    always_comb begin
        rdata_shift = bus.hrdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00: begin
                lane_wdata = {24'd0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                lane_rdata = {24'd0, rdata_shift[7:0]};
            end
            2'b01: begin
                lane_wdata = addr_q[1] ? {wdata_q[15:0], 16'd0} : {16'd0, wdata_q[15:0]};
                lane_rdata = addr_q[1] ? {16'd0, bus.hrdata[31:16]} : {16'd0, bus.hrdata[15:0]};
            end
            default: begin
                lane_wdata = wdata_q;
                lane_rdata = bus.hrdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_cmd) begin
                wr_q    <= bus.cmd_write;
                addr_q  <= bus.cmd_addr;
                size_q  <= bus.cmd_size;
                wdata_q <= bus.cmd_wdata;
            end
            if (rsp_load) begin
                rdata_q <= rsp_data_nxt;
                err_q   <= rsp_err_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        load_cmd     = 1'b0;
        rsp_load     = 1'b0;
        rsp_err_nxt  = 1'b0;
        rsp_data_nxt = '0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_illegal) begin
                        state_nxt   = RESP;
                        rsp_load    = 1'b1;
                        rsp_err_nxt = 1'b1;
                    end else begin
                        state_nxt = ADDR;
                        load_cmd  = 1'b1;
                    end
                end
            end
            ADDR: if (bus.hready) state_nxt = DATA;
            DATA: begin
                // hready with hresp is a protocol violation and is reported as an error.
                if (bus.hready) begin
                    state_nxt    = RESP;
                    rsp_load     = 1'b1;
                    rsp_err_nxt  = bus.hresp;
                    rsp_data_nxt = (bus.hresp || wr_q) ? '0 : lane_rdata;
                end else if (bus.hresp) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                if (bus.hready) begin
                    state_nxt   = RESP;
                    rsp_load    = 1'b1;
                    rsp_err_nxt = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = err_q;
        bus.hsel      = (state == ADDR);
        bus.htrans    = (state == ADDR) ? 2'b10 : 2'b00;
        bus.hburst    = '0;
        bus.haddr     = '0;
        bus.hsize     = '0;
        bus.hwrite    = 1'b0;
        bus.hwdata    = '0;
        if (state == ADDR || state == DATA || state == ERR) begin
            bus.haddr  = addr_q;
            bus.hsize  = size_q;
            bus.hwrite = wr_q;
        end
        if ((state == DATA || state == ERR) && wr_q)
            bus.hwdata = lane_wdata;
    end
endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; it SHALL have no parameters.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accept; a command is taken on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  8  byte address.
REQ-008 cmd_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 cmd_wdata  input  32  write data, LSB-aligned.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_rdata  output  32  read data, zero-extended and LSB-aligned; 0 for writes and on error.
REQ-012 rsp_error  output  1  error flag, qualified by rsp_valid.
REQ-013 hsel, haddr[7:0], htrans[1:0], hsize[1:0], hwrite, hburst[2:0], hwdata[31:0]  outputs  AHB-Lite master-side signals.
REQ-014 hrdata[31:0], hready, hresp  inputs  AHB-Lite slave-side signals.

Function
REQ-015 The FSM SHALL have five states: IDLE, ADDR, DATA, ERR, RESP.
REQ-016 IDLE: cmd_ready = 1; all other states: cmd_ready = 0.
REQ-017 IDLE, legal accepted command: cmd_write, cmd_addr, cmd_size and cmd_wdata SHALL be registered; next state ADDR.
REQ-018 Illegal commands SHALL produce no bus activity; next state RESP with rsp_error = 1. Illegal means any of:
- cmd_size = 11
- halfword with cmd_addr[0] = 1
- word with cmd_addr[1:0] != 00
REQ-019 ADDR outputs SHALL be: hsel = 1, htrans = 10 (NONSEQ), haddr/hsize/hwrite from the registered command.
REQ-020 ADDR SHALL advance to DATA on an edge with hready = 1, and SHALL hold while hready = 0.
REQ-021 In every state other than ADDR: htrans = 00 and hsel = 0.
REQ-022 hburst SHALL be 000 at all times.
REQ-023 haddr, hsize and hwrite SHALL hold their registered values from ADDR through DATA and ERR.
REQ-024 DATA, write: hwdata SHALL carry the data on the lane selected by haddr[1:0]; all other lanes 0.
- byte: lane haddr[1:0], bits 8*haddr+7 : 8*haddr
- halfword: bits [15:0] if haddr[1] = 0, else bits [31:16]
- word: all 32 bits
REQ-025 hwdata SHALL be 0 outside DATA/ERR, and always 0 for reads.
REQ-026 DATA exit conditions:
- hready = 1, hresp = 0: capture the lane-extracted hrdata (same lane rule as REQ-024, zero-extended) into rsp_rdata; next RESP, rsp_error = 0.
- hready = 0, hresp = 1: next ERR.
- hready = 0, hresp = 0: stay in DATA (wait states, unbounded).
- hready = 1, hresp = 1: protocol violation, treated as an error; next RESP, rsp_error = 1.
REQ-027 ERR SHALL advance to RESP with rsp_error = 1 on the edge where hready = 1.
REQ-028 RESP: rsp_valid = 1 for exactly one cycle; next state IDLE.
REQ-029 rsp_rdata and rsp_error SHALL hold their values until the next RESP.
REQ-030 Zero-wait-state latency SHALL be: accept edge -> ADDR (1 cycle) -> DATA (1 cycle) -> RESP; rsp_valid asserts 3 cycles after the accept edge.
REQ-031 Minimum command-to-command spacing SHALL be 4 cycles; cmd_valid presented outside IDLE is ignored (no queuing).

Reset
REQ-032 While n_rst = 0, regardless of in-flight transfer: state = IDLE and every output = 0 except cmd_ready = 1.
REQ-033 An in-flight transfer SHALL be abandoned with no rsp_valid.
REQ-034 The first command SHALL be accepted on the first rising edge after n_rst deasserts with cmd_valid = 1.

Verification
REQ-035 Word read at 0x04, slave zero-wait with hrdata = 0xDEADBEEF:
- ADDR cycle: htrans = 10, hsize = 10, hwrite = 0
- rsp_valid 3 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_error = 0
REQ-036 Byte write at 0x0B, cmd_wdata = 0x000000A5:
- hsize = 00, haddr = 0x0B, hwdata = 0xA5000000 in DATA
REQ-037 Halfword read at 0x02, hrdata = 0x1234ABCD, 2 wait states:
- DATA held 3 cycles, htrans = 00 throughout DATA
- rsp_rdata = 0x00001234, rsp_valid 5 cycles after accept
REQ-038 Write at 0x0C, slave answers hresp = 1 / hready = 0, then hresp = 1 / hready = 1:
- ERR visited, htrans = 00 in both cycles
- rsp_valid with rsp_error = 1, rsp_rdata = 0
REQ-039 Halfword at 0x03 and cmd_size = 11 commands:
- hsel and htrans never asserted
- rsp_valid next cycle with rsp_error = 1
REQ-040 n_rst pulsed low during a DATA wait state:
- all bus outputs 0 immediately, cmd_ready = 1, no rsp_valid
- the next command completes normally
